mem_wb_stage: RTL and testbench
===============================

MEM_WB_STAGE -- requirements
Module: mem_wb_stage

Interface
REQ-001 SHALL have parameter DEPTH, default 64, data-memory depth in 32-bit words (power of two, 4..1024).
REQ-002 SHALL have parameter AW, default log2(DEPTH), word-index width.
REQ-003 clk  in  1  single clock; all state updates on posedge clk.
REQ-004 rst_n  in  1  reset, synchronous, active-low.
REQ-005 stall  in  1  hold MEM/WB outputs, block memory write.
REQ-006 flush  in  1  replace current instruction with a bubble.
REQ-007 adder2  in  32  branch target from EX/MEM register.
REQ-008 zero  in  1  ALU zero flag from EX/MEM register.
REQ-009 Aluresult  in  32  byte address / ALU result.
REQ-010 ReadData2  in  32  store data.
REQ-011 Mux  in  5  destination register number.
REQ-012 WB  in  2  {RegWrite, MemToReg}.
REQ-013 Memoria  in  3  {Branch, MemRead, MemWrite}.
REQ-014 PCSrc  out  1  branch taken, combinational.
REQ-015 branch_target  out  32  combinational copy of adder2.
REQ-016 salida_ReadData  out  32  registered load data.
REQ-017 salida_Aluresult  out  32  registered Aluresult.
REQ-018 salida_Mux  out  5  registered destination register.
REQ-019 salida_WB  out  2  registered WB control.
REQ-020 mem_error  out  1  sticky access-fault flag.
REQ-021 store_count  out  16  count of committed stores.

Function
REQ-022 PCSrc SHALL equal Memoria[2] & zero & ~flush; branch_target SHALL equal adder2 at all times.
REQ-023 access = Memoria[1] | Memoria[0]; word index = Aluresult[AW+1:2].
REQ-024 fault SHALL be access & ((Aluresult[1:0] != 0) | (Aluresult[31:AW+2] != 0)).
REQ-025 Priority per posedge: reset > flush > stall > normal.
REQ-026 Normal, no fault: salida_Aluresult<=Aluresult, salida_Mux<=Mux, salida_WB<=WB; one-cycle latency.
REQ-027 Normal, Memoria[1]=1, no fault: salida_ReadData<=mem[index] as held before this edge; else salida_ReadData<=0.
REQ-028 Normal, Memoria[0]=1, no fault: mem[index]<=ReadData2, store_count increments, wrapping 0xFFFF->0x0000.
REQ-029 Memoria[1] and Memoria[0] both set: write SHALL be performed, salida_ReadData SHALL return the pre-write word.
REQ-030 Fault (normal path): no write, no count; salida_ReadData<=0, salida_WB<=2'b00, salida_Aluresult/salida_Mux still captured; mem_error<=1.
REQ-031 stall=1 (flush=0): all registered outputs, store_count and memory SHALL hold; mem_error SHALL not change.
REQ-032 flush=1: salida_ReadData, salida_Aluresult, salida_Mux, salida_WB <= 0; no write, no count, mem_error unchanged.
REQ-033 mem_error SHALL stay 1 until reset.
REQ-034 Memory array SHALL not be reset; contents are undefined until written.

Reset
REQ-035 rst_n=0 at posedge: salida_ReadData, salida_Aluresult, salida_Mux, salida_WB, mem_error, store_count <= 0; no memory write that edge.
REQ-036 Reset asserted mid-stall or coincident with a store SHALL win: store dropped, outputs cleared.
REQ-037 PCSrc/branch_target SHALL remain combinational and are not affected by rst_n.

Verification
REQ-038 Store Aluresult=0x10, ReadData2=0xDEADBEEF, Memoria=001; then load Memoria=010, WB=11, Mux=5 -> next cycle salida_ReadData=0xDEADBEEF, salida_WB=11, salida_Mux=5, store_count=1.
REQ-039 Store to Aluresult=0x12 -> mem_error=1, salida_WB=00, store_count unchanged; later load of 0x10 still returns old word.
REQ-040 Memoria=100, zero=1, adder2=0x40 -> PCSrc=1, branch_target=0x40 same cycle; with flush=1 -> PCSrc=0.
REQ-041 stall=1 for 3 cycles while store presented -> outputs frozen, memory unchanged, store_count unchanged; flush+stall together -> outputs zero.
REQ-042 0x10000 stores to valid addresses -> store_count wraps to 0; rst_n=0 during a store -> all outputs 0, word not written.

Source files
------------

// File: rtl/mem_wb_stage_if.sv
// rtl/mem_wb_stage_if.sv - MEM/WB stage bus: EX/MEM inputs, control, and stage outputs
interface mem_wb_stage_if;
  logic        stall;
  logic        flush;
  logic [31:0] adder2;
  logic        zero;
  logic [31:0] Aluresult;
  logic [31:0] ReadData2;
  logic [4:0]  Mux;
  logic [1:0]  WB;
  logic [2:0]  Memoria;
  logic        PCSrc;
  logic [31:0] branch_target;
  logic [31:0] salida_ReadData;
  logic [31:0] salida_Aluresult;
  logic [4:0]  salida_Mux;
  logic [1:0]  salida_WB;
  logic        mem_error;
  logic [15:0] store_count;

  // Driver side: supplies EX/MEM register contents and pipeline control
  modport master (
    output stall, flush, adder2, zero, Aluresult, ReadData2, Mux, WB, Memoria,
    input  PCSrc, branch_target, salida_ReadData, salida_Aluresult, salida_Mux,
           salida_WB, mem_error, store_count
  );

  // Stage side: consumes EX/MEM contents, produces MEM/WB register outputs
  modport slave (
    input  stall, flush, adder2, zero, Aluresult, ReadData2, Mux, WB, Memoria,
    output PCSrc, branch_target, salida_ReadData, salida_Aluresult, salida_Mux,
           salida_WB, mem_error, store_count
  );
endinterface

// File: rtl/mem_wb_stage.sv
// rtl/mem_wb_stage.sv - data-memory access and MEM/WB pipeline register
module mem_wb_stage #(
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input logic           clk,
  input logic           rst_n,
  mem_wb_stage_if.slave bus
);

  logic [31:0] mem [DEPTH];

  logic          access;
  logic          fault;
  logic [AW-1:0] idx;
  logic          we;

  logic [31:0] rdata_q;
  logic [31:0] alu_q;
  logic [4:0]  mux_q;
  logic [1:0]  wb_q;
  logic        err_q;
  logic [15:0] cnt_q;

  assign access = bus.Memoria[1] | bus.Memoria[0];
  assign idx    = bus.Aluresult[AW+1:2];
  // Misaligned words or addresses beyond the array are faults, but only for real accesses
  assign fault  = access & ((bus.Aluresult[1:0] != 2'b00) |
                            (bus.Aluresult[31:AW+2] != '0));
  assign we     = rst_n & ~bus.flush & ~bus.stall & bus.Memoria[0] & ~fault;

  // Branch resolution stays combinational so the fetch stage sees it this cycle
  assign bus.PCSrc         = bus.Memoria[2] & bus.zero & ~bus.flush;
  assign bus.branch_target = bus.adder2;

  assign bus.salida_ReadData  = rdata_q;
  assign bus.salida_Aluresult = alu_q;
  assign bus.salida_Mux       = mux_q;
  assign bus.salida_WB        = wb_q;
  assign bus.mem_error        = err_q;
  assign bus.store_count      = cnt_q;

  // Data memory write port; the array itself is never cleared
  always_ff @(posedge clk) begin
    if (we) begin
      mem[idx] <= bus.ReadData2;
    end
  end

  // MEM/WB register: reset beats flush beats stall; a load reads the pre-write word
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdata_q <= '0;
      alu_q   <= '0;
      mux_q   <= '0;
      wb_q    <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else if (bus.flush) begin
      rdata_q <= '0;
      alu_q   <= '0;
      mux_q   <= '0;
      wb_q    <= '0;
    end else if (!bus.stall) begin
      alu_q <= bus.Aluresult;
      mux_q <= bus.Mux;
      if (fault) begin
        rdata_q <= '0;
        wb_q    <= 2'b00;
        err_q   <= 1'b1;
      end else begin
        wb_q    <= bus.WB;
        rdata_q <= bus.Memoria[1] ? mem[idx] : 32'd0;
        if (bus.Memoria[0]) begin
          cnt_q <= cnt_q + 16'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb/tb_mem_wb_stage.sv - table-driven self-checking bench for mem_wb_stage
module tb_mem_wb_stage;

  logic clk;
  logic rst_n;

  mem_wb_stage_if bus ();

  mem_wb_stage #(.DEPTH(64)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        rst_n;
    logic        stall;
    logic        flush;
    logic        zero;
    logic [31:0] adder2;
    logic [31:0] alu;
    logic [31:0] rd2;
    logic [4:0]  mux;
    logic [1:0]  wb;
    logic [2:0]  mem;
    logic        pcsrc;
    logic [31:0] bt;
    logic [31:0] rdata;
    logic [31:0] alu_o;
    logic [4:0]  mux_o;
    logic [1:0]  wb_o;
    logic        err;
    logic [15:0] cnt;
  } vec_t;

  localparam int NV = 19;
  vec_t vt [NV];

  int n_vec;
  int n_miss;

  task automatic chk(input string name, input int v, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s step %0d: got %h expected %h", name, v, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic s, input logic f, input logic z,
                       input logic [31:0] a2, input logic [31:0] alu, input logic [31:0] rd2,
                       input logic [4:0] mx, input logic [1:0] wb, input logic [2:0] m);
    rst_n         = r;
    bus.stall     = s;
    bus.flush     = f;
    bus.zero      = z;
    bus.adder2    = a2;
    bus.Aluresult = alu;
    bus.ReadData2 = rd2;
    bus.Mux       = mx;
    bus.WB        = wb;
    bus.Memoria   = m;
  endtask

  initial begin
    n_vec  = 0;
    n_miss = 0;

    //          rst  stl flu zer adder2        alu           rd2           mux    wb     mem     pcs bt            rdata         alu_o         mux_o  wb_o   err  cnt
    vt[0]  = '{1'b0,1'b0,1'b0,1'b0,32'h0,        32'h0,        32'h0,        5'd0,  2'b00, 3'b000, 1'b0,32'h0,        32'h0,        32'h0,        5'd0,  2'b00, 1'b0,16'd0};
    vt[1]  = '{1'b1,1'b0,1'b0,1'b0,32'h0,        32'h10,       32'hDEADBEEF, 5'd0,  2'b00, 3'b001, 1'b0,32'h0,        32'h0,        32'h10,       5'd0,  2'b00, 1'b0,16'd1};
    vt[2]  = '{1'b1,1'b0,1'b0,1'b0,32'h0,        32'h10,       32'h0,        5'd5,  2'b11, 3'b010, 1'b0,32'h0,        32'hDEADBEEF, 32'h10,       5'd5,  2'b11, 1'b0,16'd1};
    vt[3]  = '{1'b1,1'b0,1'b0,1'b1,32'h40,       32'h20,       32'h0,        5'd3,  2'b10, 3'b100, 1'b1,32'h40,       32'h0,        32'h20,       5'd3,  2'b10, 1'b0,16'd1};
    vt[4]  = '{1'b1,1'b0,1'b1,1'b1,32'h40,       32'h20,       32'h0,        5'd3,  2'b10, 3'b100, 1'b0,32'h40,       32'h0,        32'h0,        5'd0,  2'b00, 1'b0,16'd1};
    vt[5]  = '{1'b1,1'b0,1'b0,1'b0,32'h0,        32'h14,       32'h11112222, 5'd2,  2'b01, 3'b001, 1'b0,32'h0,        32'h0,        32'h14,       5'd2,  2'b01, 1'b0,16'd2};
    vt[6]  = '{1'b1,1'b0,1'b0,1'b0,32'h0,        32'h14,       32'h33334444, 5'd7,  2'b11, 3'b011, 1'b0,32'h0,        32'h11112222, 32'h14,       5'd7,  2'b11, 1'b0,16'd3};
    vt[7]  = '{1'b1,1'b0,1'b0,1'b0,32'h0,        32'h14,       32'h0,        5'd7,  2'b11, 3'b010, 1'b0,32'h0,        32'h33334444, 32'h14,       5'd7,  2'b11, 1'b0,16'd3};
    vt[8]  = '{1'b1,1'b0,1'b0,1'b0,32'h0,        32'h12,       32'hBADBAD00, 5'd9,  2'b11, 3'b001, 1'b0,32'h0,        32'h0,        32'h12,       5'd9,  2'b00, 1'b1,16'd3};
    vt[9]  = '{1'b1,1'b0,1'b0,1'b0,32'h0,        32'h10,       32'h0,        5'd5,  2'b11, 3'b010, 1'b0,32'h0,        32'hDEADBEEF, 32'h10,       5'd5,  2'b11, 1'b1,16'd3};
    vt[10] = '{1'b1,1'b0,1'b0,1'b0,32'h0,        32'h100,      32'h0,        5'd4,  2'b11, 3'b010, 1'b0,32'h0,        32'h0,        32'h100,      5'd4,  2'b00, 1'b1,16'd3};
    vt[11] = '{1'b1,1'b1,1'b0,1'b0,32'h0,        32'h10,       32'h55555555, 5'd8,  2'b11, 3'b001, 1'b0,32'h0,        32'h0,        32'h100,      5'd4,  2'b00, 1'b1,16'd3};
    vt[12] = vt[11];
    vt[13] = vt[11];
    vt[14] = '{1'b1,1'b0,1'b0,1'b0,32'h0,        32'h10,       32'h0,        5'd5,  2'b11, 3'b010, 1'b0,32'h0,        32'hDEADBEEF, 32'h10,       5'd5,  2'b11, 1'b1,16'd3};
    vt[15] = '{1'b1,1'b1,1'b1,1'b0,32'h0,        32'h10,       32'h0,        5'd5,  2'b11, 3'b010, 1'b0,32'h0,        32'h0,        32'h0,        5'd0,  2'b00, 1'b1,16'd3};
    vt[16] = '{1'b1,1'b0,1'b0,1'b0,32'h0,        32'hFFFFFFFF, 32'h0,        5'd31, 2'b10, 3'b000, 1'b0,32'h0,        32'h0,        32'hFFFFFFFF, 5'd31, 2'b10, 1'b1,16'd3};
    vt[17] = '{1'b0,1'b0,1'b0,1'b1,32'h80,       32'h10,       32'h77777777, 5'd6,  2'b11, 3'b101, 1'b1,32'h80,       32'h0,        32'h0,        5'd0,  2'b00, 1'b0,16'd0};
    vt[18] = '{1'b1,1'b0,1'b0,1'b0,32'h0,        32'h10,       32'h0,        5'd5,  2'b11, 3'b010, 1'b0,32'h0,        32'hDEADBEEF, 32'h10,       5'd5,  2'b11, 1'b0,16'd0};

    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 5'd0, 2'b00, 3'b000);

    for (int i = 0; i < NV; i++) begin
      drive(vt[i].rst_n, vt[i].stall, vt[i].flush, vt[i].zero, vt[i].adder2,
            vt[i].alu, vt[i].rd2, vt[i].mux, vt[i].wb, vt[i].mem);
      #1;
      n_vec++;
      chk("PCSrc", i, {31'd0, bus.PCSrc}, {31'd0, vt[i].pcsrc});
      chk("branch_target", i, bus.branch_target, vt[i].bt);
      @(posedge clk);
      #1;
      chk("salida_ReadData", i, bus.salida_ReadData, vt[i].rdata);
      chk("salida_Aluresult", i, bus.salida_Aluresult, vt[i].alu_o);
      chk("salida_Mux", i, {27'd0, bus.salida_Mux}, {27'd0, vt[i].mux_o});
      chk("salida_WB", i, {30'd0, bus.salida_WB}, {30'd0, vt[i].wb_o});
      chk("mem_error", i, {31'd0, bus.mem_error}, {31'd0, vt[i].err});
      chk("store_count", i, {16'd0, bus.store_count}, {16'd0, vt[i].cnt});
    end

    // store_count wrap: 65535 stores reach 0xFFFF, one more wraps to zero
    for (int k = 1; k <= 65535; k++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h20, k, 5'd1, 2'b00, 3'b001);
      @(posedge clk);
      #1;
    end
    n_vec++;
    chk("store_count_ffff", 100, {16'd0, bus.store_count}, 32'h0000FFFF);

    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h20, 32'h0001ABCD, 5'd1, 2'b00, 3'b001);
    @(posedge clk);
    #1;
    n_vec++;
    chk("store_count_wrap", 101, {16'd0, bus.store_count}, 32'h0);

    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h20, 32'h0, 5'd12, 2'b11, 3'b010);
    @(posedge clk);
    #1;
    n_vec++;
    chk("wrap_readback", 102, bus.salida_ReadData, 32'h0001ABCD);
    chk("wrap_readback_mux", 102, {27'd0, bus.salida_Mux}, 32'd12);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
